// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, Booth digit encoding and helpers for the 16x16 radix-4 Booth multiplier
//   booth_decode : 3-bit multiplier triplet -> Booth digit
//   csa          : 32-bit 3:2 compressor, returns {carry, sum}
package booth_pkg;
    localparam int OP_W   = 16;
    localparam int EXT_W  = 18;
    localparam int PROD_W = 32;
    localparam int NUM_PP = 9;

    typedef enum logic [2:0] {D_ZERO, D_P1, D_M1, D_P2, D_M2} booth_digit_t;

    function automatic booth_digit_t booth_decode(input logic [2:0] t);
        return (t == 3'b001 || t == 3'b010) ? D_P1 :
               (t == 3'b101 || t == 3'b110) ? D_M1 :
               (t == 3'b011)                ? D_P2 :
               (t == 3'b100)                ? D_M2 : D_ZERO;
    endfunction

    function automatic logic [2*PROD_W-1:0] csa(input logic [PROD_W-1:0] x, y, z);
        logic [PROD_W-1:0] c;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, x ^ y ^ z};
    endfunction
endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth partial-product row
//   trip   in  3   multiplier triplet (b[2i+1], b[2i], b[2i-1])
//   a_ext  in  18  extended multiplicand
//   pp     out 19  selected multiple, one's-complemented when negative
//   neg    out 1   +1 correction to be added at the row's LSB
module booth_pp_gen
    import booth_pkg::*;
(
    input  logic [2:0]       trip,
    input  logic [EXT_W-1:0] a_ext,
    output logic [EXT_W:0]   pp,
    output logic             neg
);
    booth_digit_t d;
    logic [EXT_W:0] mag;

    always_comb begin
        d   = booth_decode(trip);
        neg = (d == D_M1) || (d == D_M2);
        mag = (d == D_P1 || d == D_M1) ? {a_ext[EXT_W-1], a_ext} :
              (d == D_P2 || d == D_M2) ? {a_ext, 1'b0} : '0;
        pp  = mag ^ {(EXT_W+1){neg}};
    end
endmodule

// File: rtl/booth_16x16_top.sv
// booth_16x16_top: single-cycle 16x16 radix-4 Booth multiplier with registered copy
//   clk, rst          clock; asynchronous active-high reset (registered outputs only)
//   A, B              16-bit multiplicand / multiplier
//   alu_signed        1 = two's-complement operands, 0 = unsigned
//   PROD_RESULT       combinational 32-bit product
//   neg_flag          combinational negative flag (signed mode only)
//   zero_flag         combinational zero flag
//   PROD_Q, neg_q, zero_q   the above registered on clk
module booth_16x16_top
    import booth_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    input  logic              alu_signed,
    output logic [PROD_W-1:0] PROD_RESULT,
    output logic              neg_flag,
    output logic              zero_flag,
    output logic [PROD_W-1:0] PROD_Q,
    output logic              neg_q,
    output logic              zero_q
);
    logic [EXT_W-1:0]  a_ext, b_ext;
    logic [EXT_W:0]    b_trip;
    logic [EXT_W:0]    pp [NUM_PP];
    logic [NUM_PP-1:0] neg;
    logic [PROD_W-1:0] row [NUM_PP];
    logic [PROD_W-1:0] corr;
    logic [PROD_W-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6, s7, c7;

    // zero-extension in unsigned mode keeps b[17:16]=0 so 0xFFFF is not recoded as -1
    always_comb begin
        a_ext  = alu_signed ? {{(EXT_W-OP_W){A[OP_W-1]}}, A} : {{(EXT_W-OP_W){1'b0}}, A};
        b_ext  = alu_signed ? {{(EXT_W-OP_W){B[OP_W-1]}}, B} : {{(EXT_W-OP_W){1'b0}}, B};
        b_trip = {b_ext, 1'b0};
    end

    genvar i;
    generate
        for (i = 0; i < NUM_PP; i++) begin : g_pp
            booth_pp_gen u_pp (
                .trip  (b_trip[2*i+2 -: 3]),
                .a_ext (a_ext),
                .pp    (pp[i]),
                .neg   (neg[i])
            );
            assign row[i] = {{(PROD_W-EXT_W-1){pp[i][EXT_W]}}, pp[i]} << (2*i);
        end
    endgenerate

    // negation correction bits sit at distinct even positions, so they share one operand
    always_comb begin
        corr = '0;
        for (int k = 0; k < NUM_PP; k++) corr[2*k] = neg[k];
    end

    // 10 operands -> 7 -> 5 -> 4 -> 3 -> 2 through 3:2 compressors, then one CPA
    always_comb begin
        {c0, s0} = csa(row[0], row[1], row[2]);
        {c1, s1} = csa(row[3], row[4], row[5]);
        {c2, s2} = csa(row[6], row[7], row[8]);
        {c3, s3} = csa(s0, c0, s1);
        {c4, s4} = csa(c1, s2, c2);
        {c5, s5} = csa(s3, c3, s4);
        {c6, s6} = csa(s5, c5, c4);
        {c7, s7} = csa(s6, c6, corr);
        PROD_RESULT = s7 + c7;
        neg_flag    = alu_signed & PROD_RESULT[PROD_W-1];
        zero_flag   = (PROD_RESULT == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PROD_Q <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            PROD_Q <= PROD_RESULT;
            neg_q  <= neg_flag;
            zero_q <= zero_flag;
        end
    end
endmodule

// File: tb/tb_booth_16x16_top.sv
// tb_booth_16x16_top: scoreboard bench for booth_16x16_top (directed vectors plus reference-checked random)
module tb_booth_16x16_top;
    typedef struct {
        logic [31:0] p;
        logic        n;
        logic        z;
        int          idx;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        alu_signed = 1'b0;
    logic [31:0] PROD_RESULT, PROD_Q;
    logic        neg_flag, zero_flag, neg_q, zero_q;
    logic        vld = 1'b0;
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_vec = 0;

    booth_16x16_top dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .alu_signed  (alu_signed),
        .PROD_RESULT (PROD_RESULT),
        .neg_flag    (neg_flag),
        .zero_flag   (zero_flag),
        .PROD_Q      (PROD_Q),
        .neg_q       (neg_q),
        .zero_q      (zero_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [31:0] p);
        exp_t e;
        @(posedge clk);
        #1;
        A = a;
        B = b;
        alu_signed = s;
        e.p = p;
        e.n = s & p[31];
        e.z = (p == 32'h0);
        e.idx = n_vec++;
        sb.push_back(e);
        vld = 1'b1;
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa, sb_;
        logic [31:0] ua, ub;
        sa = $signed(a);
        sb_ = $signed(b);
        ua = {16'h0, a};
        ub = {16'h0, b};
        return s ? 32'(sa * sb_) : ua * ub;
    endfunction

    // monitor: checks combinational outputs against the head of the scoreboard, and the
    // registered outputs against the vector applied one cycle earlier
    initial begin
        exp_t e, prev;
        logic have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (vld) begin
                if (have_prev) begin
                    chk($sformatf("prod_q[%0d]", prev.idx), PROD_Q, prev.p);
                    chk($sformatf("neg_q[%0d]", prev.idx), {31'h0, neg_q}, {31'h0, prev.n});
                    chk($sformatf("zero_q[%0d]", prev.idx), {31'h0, zero_q}, {31'h0, prev.z});
                end
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_underflow: got empty queue expected entry");
                    have_prev = 1'b0;
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("prod[%0d]", e.idx), PROD_RESULT, e.p);
                    chk($sformatf("neg[%0d]", e.idx), {31'h0, neg_flag}, {31'h0, e.n});
                    chk($sformatf("zero[%0d]", e.idx), {31'h0, zero_flag}, {31'h0, e.z});
                    prev = e;
                    have_prev = 1'b1;
                end
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    vec_t dir [14] = '{
        '{16'h0000, 16'h0000, 1'b0, 32'h00000000},
        '{16'h0001, 16'hFFFF, 1'b0, 32'h0000FFFF},
        '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001},
        '{16'h8000, 16'h8000, 1'b0, 32'h40000000},
        '{16'h1234, 16'h5678, 1'b0, 32'h06260060},
        '{16'hFFFE, 16'h0003, 1'b0, 32'h0002FFFA},
        '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001},
        '{16'h8000, 16'h8000, 1'b1, 32'h40000000},
        '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000},
        '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000},
        '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001},
        '{16'h0000, 16'h0000, 1'b1, 32'h00000000},
        '{16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA},
        '{16'h1234, 16'h5678, 1'b1, 32'h06260060}
    };

    initial begin
        logic [15:0] ra, rb;
        #1 rst = 1'b1;
        #2;
        chk("reset_prod_q", PROD_Q, 32'h0);
        chk("reset_neg_q", {31'h0, neg_q}, 32'h0);
        chk("reset_zero_q", {31'h0, zero_q}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (dir[k]) apply(dir[k].a, dir[k].b, dir[k].s, dir[k].p);
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 20000; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                apply(ra, rb, m[0], ref_mul(ra, rb, m[0]));
            end
        end
        @(posedge clk);
        #1 vld = 1'b0;

        // mode switch alone must change the combinational product without any clock edge
        @(posedge clk);
        #1;
        A = 16'hFFFF;
        B = 16'hFFFF;
        alu_signed = 1'b0;
        #1 chk("toggle_unsigned", PROD_RESULT, 32'hFFFE0001);
        alu_signed = 1'b1;
        #1 chk("toggle_signed", PROD_RESULT, 32'h00000001);
        chk("toggle_neg", {31'h0, neg_flag}, 32'h0);

        // asynchronous reset of the registered copy in the middle of a run
        @(posedge clk);
        #1;
        A = 16'h7FFF;
        B = 16'h8000;
        alu_signed = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_prod_q", PROD_Q, 32'hC0008000);
        chk("pre_rst_neg_q", {31'h0, neg_q}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_prod_q", PROD_Q, 32'h0);
        chk("async_rst_neg_q", {31'h0, neg_q}, 32'h0);
        chk("async_rst_zero_q", {31'h0, zero_q}, 32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_prod_q", PROD_Q, 32'h0);
        rst = 1'b0;
        A = 16'h8000;
        B = 16'h0001;
        @(posedge clk);
        #1;
        chk("post_rst_prod_q", PROD_Q, 32'hFFFF8000);
        chk("post_rst_neg_q", {31'h0, neg_q}, 32'h1);
        A = 16'h0000;
        B = 16'h1234;
        @(posedge clk);
        #1;
        chk("post_rst_zero_q", {31'h0, zero_q}, 32'h1);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
